// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU front end.
//   - instruction class encodings (CLS_*)
//   - ALU opcode constants (OP_*)
//   - instruction word field positions and packed instruction layout
//   - sequencer state encoding
package cpu_pkg;

    localparam int INSTR_W = 22;

    // Instruction word fields
    localparam int CLS_HI   = 21;
    localparam int CLS_LO   = 20;
    localparam int SAVE_BIT = 19;
    localparam int OP_HI    = 18;
    localparam int OP_LO    = 16;
    localparam int A_HI     = 15;
    localparam int A_LO     = 8;
    localparam int B_HI     = 7;
    localparam int B_LO     = 0;

    // Instruction classes
    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_JMP  = 2'b01;
    localparam logic [1:0] CLS_HALT = 2'b10;
    localparam logic [1:0] CLS_NOP  = 2'b11;

    // ALU selects
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Packed view matching the field positions above (MSB first)
    typedef struct packed {
        logic [1:0] cls;
        logic       save;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/program_rom_ram.sv
// program_rom_ram: PROG_DEPTH x INSTR_W program store.
//   clk    - clock
//   reset  - async active-high, clears the read register only
//   we     - write strobe (already qualified by the caller)
//   waddr  - write address
//   wdata  - write data
//   re     - read enable
//   raddr  - read address
//   rdata  - registered read data (acts as the instruction register)
// The array itself is not reset.
import cpu_pkg::*;

module program_rom_ram #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches program words, steps the PC and issues
// ALU instructions to the execute stage over a valid/ready handshake.
//   clk, reset          - clock, async active-high reset
//   prog_we/addr/data   - program load port (honoured in IDLE/HALTED only)
//   start               - run from PC 0 (honoured in IDLE/HALTED only)
//   issue_ready         - execute stage accepts the current issue
//   issue_valid         - a/b/opcode/save carry a valid ALU instruction
//   a, b, opcode, save  - issued instruction fields (held when not valid)
//   pc                  - current program counter
//   busy, halted        - status (FETCH/EXEC, HALTED)
import cpu_pkg::*;

module instruction_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [21:0]       prog_data,
    input  logic              start,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [7:0]        a,
    output logic [7:0]        b,
    output logic [2:0]        opcode,
    output logic              save,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    state_t             state;
    logic [INSTR_W-1:0] ir_raw;
    instr_t             ir;
    logic               loadable;

    // Last issued fields, shown while issue_valid is low
    logic [7:0]         a_hold;
    logic [7:0]         b_hold;
    logic [2:0]         op_hold;
    logic               save_hold;

    assign loadable = (state == ST_IDLE) || (state == ST_HALTED);
    assign ir       = instr_t'(ir_raw);

    // Memory read register doubles as the instruction register; it is
    // loaded on the FETCH->EXEC edge.
    program_rom_ram #(
        .PROG_DEPTH (PROG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_prog (
        .clk   (clk),
        .reset (reset),
        .we    (prog_we && loadable),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (state == ST_FETCH),
        .raddr (pc),
        .rdata (ir_raw)
    );

    // Valid is driven straight from state/ir so the first issue appears one
    // edge after FETCH, and clears the instant reset asserts.
    assign issue_valid = (state == ST_EXEC) && (ir.cls == CLS_ALU);
    assign a           = issue_valid ? ir.a    : a_hold;
    assign b           = issue_valid ? ir.b    : b_hold;
    assign opcode      = issue_valid ? ir.op   : op_hold;
    assign save        = issue_valid ? ir.save : save_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            a_hold    <= '0;
            b_hold    <= '0;
            op_hold   <= '0;
            save_hold <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        pc     <= '0;
                        state  <= ST_FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (ir.cls)
                        CLS_ALU: begin
                            if (issue_ready) begin
                                a_hold    <= ir.a;
                                b_hold    <= ir.b;
                                op_hold   <= ir.op;
                                save_hold <= ir.save;
                                pc        <= pc + ADDR_W'(1);
                                state     <= ST_FETCH;
                            end
                        end
                        CLS_JMP: begin
                            pc    <= ir.b[ADDR_W-1:0];
                            state <= ST_FETCH;
                        end
                        CLS_NOP: begin
                            pc    <= pc + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                        default: begin // CLS_HALT
                            state  <= ST_HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                    endcase
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Upstream stage of the 8-bit CPU: holds a small loadable program memory, steps a program counter, decodes each word and issues (a, b, opcode, save) to the ALU/instruction-memory execute stage.
- Valid/ready handshake toward execute; supports NOP, JMP and HALT control words.
- Program is loaded through a write port while the sequencer is idle or halted.

Parameters:
- PROG_DEPTH, 16, number of program words (power of two)
- ADDR_W, 4, PC/address width, equal to log2(PROG_DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  ADDR_W  program write address
- prog_data  in  22  program word: [21:20] class, [19] save, [18:16] opcode, [15:8] a, [7:0] b
- start  in  1  begin execution at PC 0 (sampled in IDLE/HALTED only)
- issue_ready  in  1  execute stage accepts the current issue
- issue_valid  out  1  a/b/opcode/save hold a valid ALU instruction
- a  out  8  operand A
- b  out  8  operand B
- opcode  out  3  ALU select (000 add … 111 compare)
- save  out  1  store-result flag for execute stage
- pc  out  ADDR_W  current program counter
- busy  out  1  high in FETCH/EXEC
- halted  out  1  high in HALTED

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, instruction register=0, issue_valid=0, a=b=0, opcode=0, save=0, busy=0, halted=0. Program memory is not reset; bench must load it.
- Class decode: 00=ALU issue, 01=JMP (target = b[ADDR_W-1:0]), 10=HALT, 11=NOP.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: start=1 -> pc<=0, FETCH.
- FETCH: ir<=mem[pc] (synchronous read) -> EXEC.
- EXEC, ALU: issue_valid=1; a/b/opcode/save driven from ir fields. On issue_valid&&issue_ready: pc<=pc+1, go to FETCH. Otherwise stay in EXEC with all outputs stable.
- EXEC, JMP: pc<=target, go to FETCH, no issue.
- EXEC, NOP: pc<=pc+1, go to FETCH.
- EXEC, HALT: go to HALTED; pc unchanged.
- HALTED: halted=1. start=1 -> pc<=0, FETCH.
- issue_valid is only ever high in EXEC with an ALU-class word.
- Latency: start sampled at edge N -> issue_valid high after edge N+1.
- Max throughput: one ALU issue per 2 cycles.
- PC increments modulo PROG_DEPTH: PROG_DEPTH-1 wraps to 0.
- prog_we honoured only in IDLE or HALTED; ignored in FETCH/EXEC.
- start ignored in FETCH/EXEC.
- A simultaneous prog_we and start in IDLE performs both; the write lands before the FETCH read on the next edge.
- a/b/opcode/save hold their last value when issue_valid=0.

Decomposition:
- Shared package cpu_pkg: class encodings (CLS_ALU, CLS_JMP, CLS_HALT, CLS_NOP), ALU opcode constants (OP_ADD … OP_CMP), instruction field bit positions, state encoding.
- One sub-module: program_rom_ram, a PROG_DEPTH x 22 synchronous-read, single-write memory.
- FSM, PC and decode live in the top module.

Test Plan:
- Load [0] ALU add a=5 b=3 save=1, [1] ALU sub a=0xCC b=0xAA, [2] HALT; start with issue_ready=1 -> two issues (000/05/03/1, then 001/CC/AA), then halted=1, pc=2.
- Same program with issue_ready=0 for 5 cycles -> issue_valid stays 1 and a=05, b=03, opcode=000 are stable; accepted on the first ready cycle; pc then becomes 1.
- Word [0] JMP target 5, [5] ALU xor a=5 b=3, [6] NOP, [7] HALT -> single issue opcode=100; halted with pc=7.
- Fill all 16 words with NOP except [15]=ALU or -> issue at pc=15, pc wraps to 0 and execution continues; no HALT is reached.
- Assert reset during EXEC with issue_valid=1 -> outputs clear to 0 immediately, without waiting for a clock edge, and state is IDLE.
- prog_we to addr 0 during EXEC -> memory unchanged. Start in HALTED -> re-execution from pc=0.
